filter: RTL and testbench
=========================

FILTER -- requirements
Module: filter

Interface
- REQ-001: The module SHALL have parameter DEPTH, default 4, meaning the number of synchronizer/shift stages and the minimum stable-input length in clock cycles; legal range 2..16.
- REQ-002: Port p_clk_in  input  1  system clock; all state SHALL update on its rising edge only.
- REQ-003: Port p_rst  input  1  reset, asynchronous and active-high.
- REQ-004: Port sig_in  input  1  raw, possibly glitchy, asynchronous level input.
- REQ-005: Port sig_out  output  1  filtered level, registered.
- REQ-006: Port order SHALL be sig_out, p_clk_in, p_rst, sig_in, so positional instantiation works.
- REQ-007: Internal signals SHALL be named q (DEPTH-bit shift register), J and K (1-bit combinational), so that benches can probe them hierarchically.

Function
- REQ-008: On each rising p_clk_in edge, q SHALL shift as q[0] <= sig_in and q[i] <= q[i-1] for i = 1..DEPTH-1.
- REQ-009: J SHALL equal the AND of all DEPTH bits of q: 1 only when q is all ones.
- REQ-010: K SHALL equal the NOR of all DEPTH bits of q: 1 only when q is all zeros.
- REQ-011: sig_out SHALL be a JK flip-flop clocked on the rising p_clk_in edge, using J and K as they are before that edge.
  - J=1, K=0: set to 1.
  - J=0, K=1: clear to 0.
  - J=0, K=0: hold.
- REQ-012: J=1 and K=1 together is structurally impossible for DEPTH>=1; no toggle behaviour SHALL be implemented.
- REQ-013: Latency: if sig_in rises and remains high from before clock edge n, q becomes all ones after edge n+DEPTH-1, and sig_out SHALL go high after edge n+DEPTH. Falling transitions SHALL behave symmetrically.
- REQ-014: Any sig_in pulse or glitch that does not stay stable across DEPTH consecutive sampling edges SHALL leave sig_out unchanged.
- REQ-015: sig_out SHALL never change between clock edges except on reset assertion.
- REQ-016: sig_in changing coincident with a clock edge SHALL be resolved by q[0]. The filter does not guarantee metastability protection beyond that stage.

Reset
- REQ-017: While p_rst=1, q SHALL be all zeros and sig_out SHALL be 0, regardless of the clock.
- REQ-018: Reset assertion SHALL take effect immediately, without waiting for a clock edge, including mid-qualification (q partially filled).
- REQ-019: After reset is released, the first rising edge SHALL shift normally. With sig_in held high, sig_out SHALL rise DEPTH+1 edges after release.
- REQ-020: Because reset yields K=1, sig_out SHALL remain 0 after release until a qualified high level is seen.

Verification (DEPTH=4)
- REQ-021: Reset applied mid-operation with sig_out=1 -> sig_out=0 and q=0000 immediately, before the next clock edge.
- REQ-022: Reset released, sig_in=1 held steady -> q fills 0001, 0011, 0111, 1111; J=1 after the 4th edge; sig_out=1 after the 5th edge.
- REQ-023: sig_out=1 and sig_in drops to 0 for exactly 3 edges, then returns to 1 -> K never asserts and sig_out stays 1 throughout.
- REQ-024: sig_out=1 and sig_in=0 held steady -> K=1 after the 4th edge and sig_out=0 after the 5th edge.
- REQ-025: sig_in toggling every clock cycle for 20 cycles -> J=K=0 throughout and sig_out holds its prior value.
- REQ-026: Reset asserted while q=0111 and sig_in=1, then released -> qualification restarts from q=0000 and needs the full 5 edges before sig_out=1.

Source files
------------

// File: rtl/filter.sv
// filter: glitch filter that passes a level only after DEPTH consecutive identical samples
module filter #(
    parameter int DEPTH = 4
) (
    output logic sig_out,
    input  logic p_clk_in,
    input  logic p_rst,
    input  logic sig_in
);
    logic [DEPTH-1:0] q;
    logic             J;
    logic             K;
    // Sample history; q[0] is the first (and only) resolving stage for the asynchronous input
    always_ff @(posedge p_clk_in or posedge p_rst)
        if (p_rst) q <= '0;
        else       q <= {q[DEPTH-2:0], sig_in};
    // Qualified-high and qualified-low detectors; both can never be true at once
    always_comb begin
        J = &q;
        K = ~|q;
    end
    // JK output register: set on a qualified high, clear on a qualified low, otherwise hold
    always_ff @(posedge p_clk_in or posedge p_rst)
        if (p_rst) sig_out <= 1'b0;
        else       sig_out <= J ? 1'b1 : (K ? 1'b0 : sig_out);
endmodule

// File: tb/tb_filter.sv
// tb_filter: vector table with scoreboard queue plus hand-written reset corner cases for filter
module tb_filter;
    logic sig_out;
    logic p_clk_in = 1'b0;
    logic p_rst    = 1'b1;
    logic sig_in   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic       din;
        logic [3:0] exp_q;
        logic       exp_j;
        logic       exp_k;
        logic       exp_out;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    filter #(.DEPTH(4)) dut (
        .sig_out (sig_out),
        .p_clk_in(p_clk_in),
        .p_rst   (p_rst),
        .sig_in  (sig_in)
    );

    always #5 p_clk_in = ~p_clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic d, input logic [3:0] q, input logic j,
                       input logic k, input logic o);
        vec_t v;
        v.rst = r; v.din = d; v.exp_q = q; v.exp_j = j; v.exp_k = k; v.exp_out = o;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t exp;
        int   n;
        // reset state before any clock edge
        #1;
        chk("reset_out", {31'b0, sig_out}, 32'd0);
        chk("reset_q", {28'b0, dut.q}, 32'd0);
        chk("reset_k", {31'b0, dut.K}, 32'd1);
        // vectors: expected values seen just after each rising edge
        add(1, 0, 4'b0000, 0, 1, 0);
        add(0, 1, 4'b0001, 0, 0, 0);
        add(0, 1, 4'b0011, 0, 0, 0);
        add(0, 1, 4'b0111, 0, 0, 0);
        add(0, 1, 4'b1111, 1, 0, 0);
        add(0, 1, 4'b1111, 1, 0, 1);
        add(0, 0, 4'b1110, 0, 0, 1);
        add(0, 0, 4'b1100, 0, 0, 1);
        add(0, 0, 4'b1000, 0, 0, 1);
        add(0, 1, 4'b0001, 0, 0, 1);
        add(0, 1, 4'b0011, 0, 0, 1);
        add(0, 1, 4'b0111, 0, 0, 1);
        add(0, 1, 4'b1111, 1, 0, 1);
        add(0, 0, 4'b1110, 0, 0, 1);
        add(0, 0, 4'b1100, 0, 0, 1);
        add(0, 0, 4'b1000, 0, 0, 1);
        add(0, 0, 4'b0000, 0, 1, 1);
        add(0, 0, 4'b0000, 0, 1, 0);
        for (int i = 0; i < 20; i++)
            add(0, (i % 2 == 0), (i == 0) ? 4'b0001 : (i == 1) ? 4'b0010 :
                (i % 2 == 0) ? 4'b0101 : 4'b1010, 0, 0, 0);
        foreach (vecs[i]) begin
            @(negedge p_clk_in);
            p_rst  = vecs[i].rst;
            sig_in = vecs[i].din;
            sb.push_back(vecs[i]);
            @(posedge p_clk_in);
            #1;
            exp = sb.pop_front();
            chk($sformatf("v%0d_q", i), {28'b0, dut.q}, {28'b0, exp.exp_q});
            chk($sformatf("v%0d_j", i), {31'b0, dut.J}, {31'b0, exp.exp_j});
            chk($sformatf("v%0d_k", i), {31'b0, dut.K}, {31'b0, exp.exp_k});
            chk($sformatf("v%0d_out", i), {31'b0, sig_out}, {31'b0, exp.exp_out});
        end
        // async reset while sig_out=1
        @(negedge p_clk_in);
        sig_in = 1'b1;
        repeat (5) @(posedge p_clk_in);
        #1;
        chk("pre_reset_out", {31'b0, sig_out}, 32'd1);
        @(negedge p_clk_in);
        #2;
        p_rst = 1'b1;
        #1;
        chk("async_rst_out", {31'b0, sig_out}, 32'd0);
        chk("async_rst_q", {28'b0, dut.q}, 32'd0);
        // reset mid-qualification, then full restart
        @(negedge p_clk_in);
        p_rst = 1'b0;
        repeat (3) @(posedge p_clk_in);
        #1;
        chk("partial_q", {28'b0, dut.q}, 32'b0111);
        chk("partial_out", {31'b0, sig_out}, 32'd0);
        @(negedge p_clk_in);
        #1;
        p_rst = 1'b1;
        #1;
        chk("mid_rst_q", {28'b0, dut.q}, 32'd0);
        chk("mid_rst_out", {31'b0, sig_out}, 32'd0);
        @(negedge p_clk_in);
        p_rst = 1'b0;
        n = 0;
        while (n < 12) begin
            @(posedge p_clk_in);
            #1;
            n++;
            if (sig_out) break;
        end
        chk("restart_edges", n, 32'd5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
